// File: rtl/round_sequencer_if.sv
// Handshake bundle between the round sequencer and the datapath blocks it steers.
//   master : the sequencer; takes confirm/timer/compare inputs and drives
//            compare start, timer control, input enable and game status.
//   slave  : the datapath side; mirror image of master.
interface round_sequencer_if;
  logic       confirm;       // one-cycle confirm pulse
  logic       timer_zero;    // level, timer reached 0
  logic       cmp_done;      // one-cycle pulse, cmp_result valid with it
  logic [1:0] cmp_result;    // 00 equal, 01 low, 10 high, 11 illegal
  logic       cmp_start;     // one-cycle pulse starting a comparison
  logic       timer_load;    // one-cycle timer reload pulse
  logic       timer_run;     // timer counts while high
  logic       input_en;      // digit buttons accepted while high
  logic [1:0] round;         // current round
  logic [1:0] max_digits;    // round + 1
  logic [2:0] guesses_left;  // remaining guesses
  logic [1:0] hint;          // last wrong-guess hint
  logic [1:0] win_lose;      // 00 playing, 01 win, 10 lose

  modport master (
    input  confirm, timer_zero, cmp_done, cmp_result,
    output cmp_start, timer_load, timer_run, input_en,
    output round, max_digits, guesses_left, hint, win_lose
  );

  modport slave (
    output confirm, timer_zero, cmp_done, cmp_result,
    input  cmp_start, timer_load, timer_run, input_en,
    input  round, max_digits, guesses_left, hint, win_lose
  );
endinterface

// File: rtl/round_sequencer.sv
// Game-flow controller for the number-guessing datapath. Sequences each round
// (load timer, accept input, launch a comparison, show the hint), counts
// guesses, advances rounds/difficulty and declares win or lose.
// Ports:
//   clk    system clock
//   rst    asynchronous active-high reset
//   sq_io  round_sequencer_if master modport (all outputs registered)
module round_sequencer #(
  parameter int unsigned MAX_GUESSES = 5,
  parameter int unsigned NUM_ROUNDS  = 3,
  parameter int unsigned SHOW_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  round_sequencer_if.master sq_io
);

  localparam int unsigned     CntW      = $clog2(SHOW_CYCLES + 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(SHOW_CYCLES - 1);
  localparam logic [2:0]      GuessMax  = 3'(MAX_GUESSES);
  localparam logic [1:0]      LastRound = 2'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StGuess, StCompare, StShow, StNext, StWin, StLose
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      round_q, round_d;
  logic [1:0]      max_digits_q, max_digits_d;
  logic [2:0]      guesses_q, guesses_d;
  logic [1:0]      hint_q, hint_d;
  logic [1:0]      win_lose_q, win_lose_d;
  logic            cmp_start_q, cmp_start_d;
  logic            timer_load_q, timer_load_d;
  logic            guess_en_q, guess_en_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    round_d      = round_q;
    max_digits_d = max_digits_q;
    guesses_d    = guesses_q;
    hint_d       = hint_q;
    win_lose_d   = win_lose_q;

    unique case (state_q)
      StIdle: begin
        if (sq_io.confirm) state_d = StLoad;
      end
      StLoad: begin
        guesses_d = GuessMax;
        hint_d    = 2'b00;
        state_d   = StGuess;
      end
      StGuess: begin
        // Timeout beats a simultaneous confirm.
        if (sq_io.timer_zero) begin
          state_d    = StLose;
          win_lose_d = 2'b10;
        end else if (sq_io.confirm) begin
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (sq_io.cmp_done) begin
          case (sq_io.cmp_result)
            2'b00: begin
              if (round_q == LastRound) begin
                state_d    = StWin;
                win_lose_d = 2'b01;
              end else begin
                state_d = StNext;
              end
            end
            2'b01, 2'b10: begin
              hint_d    = sq_io.cmp_result;
              guesses_d = guesses_q - 3'd1;
              if (guesses_q == 3'd1) begin
                state_d    = StLose;
                win_lose_d = 2'b10;
              end else begin
                state_d = StShow;
                cnt_d   = '0;
              end
            end
            default: ;  // illegal result: keep waiting
          endcase
        end
      end
      StShow: begin
        if (cnt_q == ShowLast) state_d = StGuess;
        else                   cnt_d   = cnt_q + CntW'(1);
      end
      StNext: begin
        round_d      = round_q + 2'd1;
        max_digits_d = round_q + 2'd2;
        state_d      = StLoad;
      end
      StWin, StLose: begin
        if (sq_io.confirm) begin
          state_d      = StIdle;
          round_d      = 2'd0;
          max_digits_d = 2'd1;
          guesses_d    = GuessMax;
          hint_d       = 2'b00;
          win_lose_d   = 2'b00;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered strobes/levels are derived from the state being entered.
    cmp_start_d  = (state_d == StCompare) && (state_q != StCompare);
    timer_load_d = (state_d == StLoad);
    guess_en_d   = (state_d == StGuess);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      round_q      <= 2'd0;
      max_digits_q <= 2'd1;
      guesses_q    <= GuessMax;
      hint_q       <= 2'b00;
      win_lose_q   <= 2'b00;
      cmp_start_q  <= 1'b0;
      timer_load_q <= 1'b0;
      guess_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      round_q      <= round_d;
      max_digits_q <= max_digits_d;
      guesses_q    <= guesses_d;
      hint_q       <= hint_d;
      win_lose_q   <= win_lose_d;
      cmp_start_q  <= cmp_start_d;
      timer_load_q <= timer_load_d;
      guess_en_q   <= guess_en_d;
    end
  end

  assign sq_io.cmp_start    = cmp_start_q;
  assign sq_io.timer_load   = timer_load_q;
  assign sq_io.timer_run    = guess_en_q;
  assign sq_io.input_en     = guess_en_q;
  assign sq_io.round        = round_q;
  assign sq_io.max_digits   = max_digits_q;
  assign sq_io.guesses_left = guesses_q;
  assign sq_io.hint         = hint_q;
  assign sq_io.win_lose     = win_lose_q;

endmodule
